// File: rtl/cache_pkg.sv
// Constants, FSM state type and address helper shared by the 4-word-line cache
// and its miss-handling filler.
package cache_pkg;

    localparam int LINE_WORDS           = 4;
    localparam int WORD_OFFSET_BITWIDTH = 2;
    localparam int BYTE_OFFSET_BITWIDTH = 2;
    localparam int WORD_BITWIDTH        = 32;
    localparam int LINE_BITWIDTH        = LINE_WORDS * WORD_BITWIDTH;
    localparam int ADDR_BITWIDTH        = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_RD_CMD,
        ST_RD_DATA,
        ST_DONE
    } filler_state_t;

    // Base byte address of the line holding addr (word and byte offsets cleared).
    function automatic logic [ADDR_BITWIDTH-1:0] line_base(input logic [ADDR_BITWIDTH-1:0] addr);
        logic [ADDR_BITWIDTH-1:0] mask;
        mask = '1;
        mask[WORD_OFFSET_BITWIDTH+BYTE_OFFSET_BITWIDTH-1:0] = '0;
        return addr & mask;
    endfunction

endpackage

// File: rtl/line_beat_assembler.sv
// One cache line plus a beat counter; serves either as a word-by-word source
// (writeback) or as a word-by-word sink (fill).
module line_beat_assembler
    import cache_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            load,
    input  logic [LINE_BITWIDTH-1:0]        load_line,
    input  logic                            clr,
    input  logic                            step,
    input  logic                            wr_en,
    input  logic [WORD_BITWIDTH-1:0]        wr_word,
    input  logic [WORD_OFFSET_BITWIDTH-1:0] sel_ix,
    output logic [WORD_BITWIDTH-1:0]        sel_word,
    output logic [WORD_OFFSET_BITWIDTH-1:0] beat,
    output logic [LINE_BITWIDTH-1:0]        line
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
            line <= '0;
        end else if (load) begin
            beat <= '0;
            line <= load_line;
        end else if (clr) begin
            beat <= '0;
        end else begin
            if (wr_en)
                line[beat*WORD_BITWIDTH +: WORD_BITWIDTH] <= wr_word;
            if (step)
                beat <= beat + 1'b1;
        end
    end

    assign sel_word = line[sel_ix*WORD_BITWIDTH +: WORD_BITWIDTH];

endmodule

// File: rtl/cache_line_filler.sv
// Cache miss handler: optional dirty-line writeback, then a 4-beat line fetch
// from the burst RAM controller, delivered to the cache as a one-cycle pulse.
module cache_line_filler
    import cache_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int LINE_IX_BITWIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_fill,
    input  logic [ADDRESS_BITWIDTH-1:0] req_address,
    input  logic                        req_writeback,
    input  logic [ADDRESS_BITWIDTH-1:0] wb_address,
    input  logic [LINE_BITWIDTH-1:0]    wb_line,
    output logic                        busy,
    output logic [LINE_BITWIDTH-1:0]    fill_line,
    output logic                        fill_valid,
    output logic                        ram_cmd_en,
    output logic                        ram_cmd,
    output logic [ADDRESS_BITWIDTH-1:0] ram_addr,
    output logic [WORD_BITWIDTH-1:0]    ram_wr_data,
    input  logic                        ram_busy,
    input  logic [WORD_BITWIDTH-1:0]    ram_rd_data,
    input  logic                        ram_rd_valid
);

    if (ADDRESS_BITWIDTH < BYTE_OFFSET_BITWIDTH + WORD_OFFSET_BITWIDTH + LINE_IX_BITWIDTH) begin : g_width_check
        $error("address too narrow to hold offsets and line index");
    end

    filler_state_t state, state_nxt;
    logic [ADDRESS_BITWIDTH-1:0]     fill_addr;
    logic [WORD_OFFSET_BITWIDTH-1:0] wb_beat, fill_beat;
    logic [WORD_BITWIDTH-1:0]        wb_next_word, fill_word_unused;
    logic [LINE_BITWIDTH-1:0]        wb_line_unused;
    logic accept, wb_take, rd_take, rd_store;

    assign accept   = (state == ST_IDLE) && req_fill;
    assign wb_take  = (state == ST_WB) && !ram_busy;
    assign rd_take  = (state == ST_RD_CMD) && !ram_busy;
    assign rd_store = (state == ST_RD_DATA) && ram_rd_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (req_fill) state_nxt = req_writeback ? ST_WB : ST_RD_CMD;
            ST_WB:      if (wb_take && wb_beat == 2'd3) state_nxt = ST_RD_CMD;
            ST_RD_CMD:  if (rd_take) state_nxt = ST_RD_DATA;
            ST_RD_DATA: if (rd_store && fill_beat == 2'd3) state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Bus outputs are computed from the next state so they appear registered
    // in the same cycle the FSM enters the corresponding state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            fill_valid  <= 1'b0;
            ram_cmd_en  <= 1'b0;
            ram_cmd     <= 1'b0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
            fill_addr   <= '0;
        end else begin
            busy       <= state_nxt != ST_IDLE;
            fill_valid <= state_nxt == ST_DONE;
            ram_cmd_en <= (state_nxt == ST_WB) || (state_nxt == ST_RD_CMD);
            ram_cmd    <= state_nxt == ST_WB;
            if (accept) begin
                fill_addr <= line_base(req_address);
                ram_addr  <= req_writeback ? line_base(wb_address) : line_base(req_address);
                if (req_writeback)
                    ram_wr_data <= wb_line[WORD_BITWIDTH-1:0];
            end else if (wb_take) begin
                if (wb_beat == 2'd3) ram_addr    <= fill_addr;
                else                 ram_wr_data <= wb_next_word;
            end
        end
    end

    // Writeback source: preload the victim line, look one word ahead of the
    // beat on the bus so the next beat is ready when the current one is taken.
    line_beat_assembler u_wb_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept && req_writeback),
        .load_line (wb_line),
        .clr       (1'b0),
        .step      (wb_take),
        .wr_en     (1'b0),
        .wr_word   ('0),
        .sel_ix    (wb_beat + 2'd1),
        .sel_word  (wb_next_word),
        .beat      (wb_beat),
        .line      (wb_line_unused)
    );

    line_beat_assembler u_fill_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (1'b0),
        .load_line ('0),
        .clr       (rd_take),
        .step      (rd_store),
        .wr_en     (rd_store),
        .wr_word   (ram_rd_data),
        .sel_ix    (2'd0),
        .sel_word  (fill_word_unused),
        .beat      (fill_beat),
        .line      (fill_line)
    );

endmodule

// File: tb/tb_cache_line_filler.sv
// Directed bench for cache_line_filler: table of fill scenarios plus
// hand-written idle-stray, mid-fill reset and back-to-back sequences.
module tb_cache_line_filler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_fill = 1'b0;
    logic [31:0]  req_address = '0;
    logic         req_writeback = 1'b0;
    logic [31:0]  wb_address = '0;
    logic [127:0] wb_line = '0;
    logic         busy;
    logic [127:0] fill_line;
    logic         fill_valid;
    logic         ram_cmd_en;
    logic         ram_cmd;
    logic [31:0]  ram_addr;
    logic [31:0]  ram_wr_data;
    logic         ram_busy = 1'b0;
    logic [31:0]  ram_rd_data = '0;
    logic         ram_rd_valid = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cache_line_filler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_fill     (req_fill),
        .req_address  (req_address),
        .req_writeback(req_writeback),
        .wb_address   (wb_address),
        .wb_line      (wb_line),
        .busy         (busy),
        .fill_line    (fill_line),
        .fill_valid   (fill_valid),
        .ram_cmd_en   (ram_cmd_en),
        .ram_cmd      (ram_cmd),
        .ram_addr     (ram_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_busy     (ram_busy),
        .ram_rd_data  (ram_rd_data),
        .ram_rd_valid (ram_rd_valid)
    );

    typedef struct {
        logic [31:0]  req_address;
        logic         wb;
        logic [31:0]  wb_address;
        logic [127:0] wb_line;
        logic [127:0] rd_line;
        int           gap;
        int           wb_stall;
        int           rd_stall;
        bit           poke;
        logic [31:0]  exp_rd_addr;
        logic [31:0]  exp_wb_addr;
        int           exp_lat;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [127:0] l, input int i);
        return l[i*32 +: 32];
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fill_valid"}, fill_valid, 0);
        chk({tag, "_fill_line"}, fill_line, 0);
        chk({tag, "_cmd_en"}, ram_cmd_en, 0);
        chk({tag, "_cmd"}, ram_cmd, 0);
        chk({tag, "_addr"}, ram_addr, 0);
        chk({tag, "_wr_data"}, ram_wr_data, 0);
    endtask

    // Plays the cache and the RAM for one request; entered and left at posedge+1.
    task automatic run_fill(input int idx);
        vec_t v;
        int wb_seen, rd_cmds, rd_seen, next_rd, wb_stall, rd_stall, fv_cycle, fv_count;
        v = vecs[idx];
        wb_seen = 0; rd_cmds = 0; rd_seen = 0; next_rd = -1;
        wb_stall = v.wb_stall; rd_stall = v.rd_stall; fv_cycle = -1; fv_count = 0;
        req_address = v.req_address; req_writeback = v.wb;
        wb_address = v.wb_address; wb_line = v.wb_line; req_fill = 1'b1;
        @(posedge clk); #1;
        req_fill = 1'b0;
        chk($sformatf("v%0d_busy_rise", idx), busy, 1);
        for (int n = 1; n <= 400; n++) begin
            ram_busy = 1'b0;
            ram_rd_valid = 1'b0;
            if (fv_cycle >= 0 && n == fv_cycle + 1) begin
                chk($sformatf("v%0d_busy_fall", idx), busy, 0);
                chk($sformatf("v%0d_fv_pulse", idx), fill_valid, 0);
                chk($sformatf("v%0d_cmd_idle", idx), ram_cmd_en, 0);
                break;
            end
            if (fill_valid) begin
                fv_count++;
                if (fv_cycle < 0) fv_cycle = n;
            end
            if (v.poke && n >= 3 && n <= 5) begin
                req_fill = 1'b1; req_address = 32'h0000_9990;
                req_writeback = 1'b1; wb_address = 32'h0000_5550;
            end else begin
                req_fill = 1'b0;
            end
            if (ram_cmd_en && ram_cmd) begin
                if (wb_seen == 1 && wb_stall > 0) begin
                    ram_busy = 1'b1;
                    wb_stall--;
                    chk($sformatf("v%0d_wb_hold", idx), ram_wr_data, word_of(v.wb_line, 1));
                end else begin
                    chk($sformatf("v%0d_wb_addr", idx), ram_addr, v.exp_wb_addr);
                    if (wb_seen < 4)
                        chk($sformatf("v%0d_wb_data%0d", idx, wb_seen), ram_wr_data, word_of(v.wb_line, wb_seen));
                    wb_seen++;
                end
            end else if (ram_cmd_en && !ram_cmd) begin
                if (rd_stall > 0) begin
                    ram_busy = 1'b1;
                    rd_stall--;
                end else begin
                    rd_cmds++;
                    chk($sformatf("v%0d_rd_addr", idx), ram_addr, v.exp_rd_addr);
                    next_rd = n + 1;
                end
            end
            if (n == next_rd && rd_seen < 4) begin
                ram_rd_valid = 1'b1;
                ram_rd_data = word_of(v.rd_line, rd_seen);
                rd_seen++;
                next_rd = n + 1 + v.gap;
            end
            @(posedge clk); #1;
        end
        req_fill = 1'b0;
        chk($sformatf("v%0d_latency", idx), fv_cycle, v.exp_lat);
        chk($sformatf("v%0d_fv_count", idx), fv_count, 1);
        chk($sformatf("v%0d_wb_beats", idx), wb_seen, v.wb ? 4 : 0);
        chk($sformatf("v%0d_rd_cmds", idx), rd_cmds, 1);
        chk($sformatf("v%0d_fill_line", idx), fill_line, v.rd_line);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0014, 1'b0, 32'h0, 128'h0,
                    128'h00000044_00000033_00000022_00000011,
                    0, 0, 0, 1'b0, 32'h0000_0010, 32'h0, 6};
        vecs[1] = '{32'h0000_1238, 1'b1, 32'h0000_4020,
                    128'h000000A3_000000A2_000000A1_000000A0,
                    128'h00000058_00000057_00000056_00000055,
                    0, 0, 0, 1'b0, 32'h0000_1230, 32'h0000_4020, 10};
        vecs[2] = '{32'h0000_2004, 1'b1, 32'h0000_4020,
                    128'h000000A3_000000A2_000000A1_000000A0,
                    128'h0BADF00D_12345678_9ABCDEF0_0F1E2D3C,
                    0, 3, 3, 1'b1, 32'h0000_2000, 32'h0000_4020, 16};
        vecs[3] = '{32'hFFFF_FFFC, 1'b0, 32'h0, 128'h0,
                    128'hCAFEBABE_DEADBEEF_FEEDFACE_01234567,
                    5, 0, 0, 1'b0, 32'hFFFF_FFF0, 32'h0, 21};
        vecs[4] = '{32'h7FFF_FFF8, 1'b1, 32'h0000_403C,
                    128'h44440000_33330000_22220000_11110000,
                    128'h80000001_40000002_20000004_10000008,
                    2, 0, 0, 1'b0, 32'h7FFF_FFF0, 32'h0000_4030, 16};

        #2 rst_n = 1'b0;
        #1 check_reset("reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_idle", busy, 0);

        run_fill(0);

        // Stray read beat while idle must not touch the held line.
        ram_rd_valid = 1'b1; ram_rd_data = 32'h0000_DEAD;
        @(posedge clk); #1;
        ram_rd_valid = 1'b0;
        chk("stray_fill_line", fill_line, vecs[0].rd_line);
        chk("stray_busy", busy, 0);

        // Back-to-back: each run_fill issues in the first idle cycle of the last.
        for (int i = 1; i < 5; i++) run_fill(i);

        // Reset after two read beats have been stored.
        req_address = 32'h0000_0104; req_writeback = 1'b0; req_fill = 1'b1;
        @(posedge clk); #1;
        req_fill = 1'b0;
        chk("mid_cmd_en", ram_cmd_en, 1);
        @(posedge clk); #1;
        ram_rd_valid = 1'b1; ram_rd_data = 32'h0000_0077;
        @(posedge clk); #1;
        ram_rd_data = 32'h0000_0088;
        @(posedge clk); #1;
        ram_rd_valid = 1'b0;
        chk("mid_partial", fill_line[63:0], 64'h00000088_00000077);
        chk("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_reset("mid_rst");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_fill(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_line_filler.md
# cache_line_filler

Miss-handling stage directly downstream of the direct-mapped 4-word-line cache. On a miss it optionally writes the dirty victim line back to external burst RAM, then fetches the 128-bit replacement line as four 32-bit beats and hands it to the cache in one cycle. It sits between the cache and the PSRAM burst controller and owns the only path from cache to external memory.

## Interface
- ADDRESS_BITWIDTH, 32, byte-address width
- LINE_IX_BITWIDTH, 10, line-index width; matches the cache
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_fill  in  1  cache reports a miss; sampled only in IDLE
- req_address  in  ADDRESS_BITWIDTH  byte address of the missed access
- req_writeback  in  1  victim line is dirty; write back before fetching
- wb_address  in  ADDRESS_BITWIDTH  byte address of the victim line
- wb_line  in  128  victim line; word 0 in [31:0]
- busy  out  1  request in progress
- fill_line  out  128  fetched line; word 0 in [31:0]
- fill_valid  out  1  one-cycle pulse; fill_line valid this cycle
- ram_cmd_en  out  1  command/beat request to RAM
- ram_cmd  out  1  1 = write, 0 = read
- ram_addr  out  ADDRESS_BITWIDTH  line base byte address
- ram_wr_data  out  32  write beat
- ram_busy  in  1  RAM cannot accept this cycle
- ram_rd_data  in  32  read beat
- ram_rd_valid  in  1  ram_rd_data valid

## Operation
- Address split: [1:0] byte, [3:2] word in line, [3+LINE_IX_BITWIDTH:4] line index, rest tag. ram_addr is always the line base: address with bits [3:0] cleared.
- States: IDLE, WB, RD_CMD, RD_DATA, DONE.
- IDLE: on req_fill, latch req_address, wb_address, wb_line, and req_writeback. Set busy. Go to WB if req_writeback is set, else RD_CMD.
- WB: drive ram_cmd_en=1, ram_cmd=1, ram_addr=wb base, ram_wr_data=wb word[beat].
  - A beat is accepted in any cycle with ram_busy=0; the beat counter (2 bits) then increments.
  - While ram_busy=1, hold all outputs.
  - After beat 3 is accepted, go to RD_CMD.
- RD_CMD: drive ram_cmd_en=1, ram_cmd=0, ram_addr=fill base. When ram_busy=0, go to RD_DATA with the beat counter cleared.
- RD_DATA: on each ram_rd_valid, store ram_rd_data into fill_line word[beat] and increment the counter.
  - Beats may arrive with any spacing.
  - After beat 3 is stored, go to DONE.
- DONE: pulse fill_valid for one cycle, then go to IDLE and clear busy.
- fill_line holds its value until the next fill overwrites it.
- req_fill while busy is ignored; the cache must hold or re-issue it.
- ram_rd_valid outside RD_DATA is ignored.
- ram_cmd_en is 0 in IDLE, RD_DATA and DONE.
- Reset mid-operation: return to IDLE immediately and discard partial beats; the RAM controller is reset from the same rst_n.

## Timing
- Reset values: busy=0, fill_valid=0, fill_line=0, ram_cmd_en=0, ram_cmd=0, ram_addr=0, ram_wr_data=0. Internal state: IDLE, beat counter 0.
- All outputs are registered.
- Read-only fill, RAM never busy, read data N cycles after command:
  - req_fill sampled at edge 0.
  - Read command is on the bus during cycle 1.
  - fill_valid is asserted one cycle after the edge that captures beat 3.
- A writeback adds exactly 4 cycles when ram_busy=0.
- busy rises the cycle after req_fill is sampled and falls the cycle after fill_valid.
- A back-to-back request is accepted in the first IDLE cycle, so the minimum gap is one cycle.

## Structure
- Shared package cache_pkg holds:
  - LINE_WORDS=4, WORD_OFFSET_BITWIDTH=2, BYTE_OFFSET_BITWIDTH=2
  - the state enum filler_state_t
  - the function line_base(addr)
  The cache uses the same constants.
- One natural sub-module: line_beat_assembler. It holds the 2-bit beat counter and the 128-bit register, exposes word-select for the write side and word-store for the read side, and is reused for both directions.
- Target: 150–250 lines of RTL.

## Test plan
- Clean fill: req_fill with req_address=0x0000_0014, RAM returns 0x11, 0x22, 0x33, 0x44 back-to-back.
  - Expect one read cmd with ram_addr=0x0000_0010.
  - Expect fill_valid for one cycle with fill_line=0x00000044_00000033_00000022_00000011.
- Dirty fill: req_writeback=1, wb_address=0x0000_4020, wb_line words 0xA0..0xA3.
  - Expect 4 write beats at ram_addr=0x0000_4020 carrying 0xA0, 0xA1, 0xA2, 0xA3, then a read cmd.
  - Expect fill_valid exactly 4 cycles later than in the clean case.
- Backpressure: ram_busy=1 for 3 cycles during WB beat 1 and during RD_CMD.
  - Expect ram_wr_data held at 0xA1 throughout the stall.
  - Expect no beat skipped or duplicated.
- Sparse read data: 5 idle cycles between rd_valid beats, plus a stray rd_valid while IDLE.
  - Expect the correct line assembled and the stray beat ignored.
- Request while busy: second req_fill mid-fill is ignored. Reissued after busy falls, it is accepted in the first IDLE cycle.
- Reset mid-RD_DATA after 2 beats: all outputs return to 0 asynchronously. A following clean fill completes correctly.
